// File: rtl/mole_spawner.sv
// Mole spawner: LFSR-placed mole, hit/miss resolution, saturating score/miss counters.
// Optional MOLE_NO_REPEAT_EN: never spawn two consecutive moles on the same LED.
module mole_spawner #(
  parameter int unsigned N_LEDS    = 8,
  parameter int unsigned GAP_TICKS = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk_game,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_LEDS-1:0] btn_pulse,
  input  logic              timeout_pulse,
  output logic              start,
  output logic [N_LEDS-1:0] mole_led,
  output logic              hit_pulse,
  output logic              miss_pulse,
  output logic [7:0]        score,
  output logic [3:0]        misses
);

  localparam int unsigned IDX_W = $clog2(N_LEDS);
  localparam int unsigned CNT_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, GAP, SPAWN, WAIT} state_t;

  state_t            state, state_d;
  logic [15:0]       lfsr;
  logic [CNT_W-1:0]  gap_cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  raw_idx;
  logic [IDX_W-1:0]  spawn_idx;
  logic              hit, tmo;

  logic              start_d, hit_d, miss_d;
  logic [N_LEDS-1:0] led_d;
  logic [7:0]        score_d;
  logic [3:0]        misses_d;

  assign raw_idx = lfsr[IDX_W-1:0];

`ifdef MOLE_NO_REPEAT_EN
  // idx_q still holds the previous mole's position here, so it doubles as the repeat reference
  assign spawn_idx = (raw_idx == idx_q) ? raw_idx + IDX_W'(1) : raw_idx;
`else
  assign spawn_idx = raw_idx;
`endif

  assign hit = (state == WAIT) && enable && btn_pulse[idx_q];
  assign tmo = (state == WAIT) && enable && timeout_pulse && !hit;

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    state_d = GAP;
        GAP:     state_d = (gap_cnt == '0) ? SPAWN : GAP;
        SPAWN:   state_d = WAIT;
        WAIT:    state_d = (hit || tmo) ? GAP : WAIT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
      idx_q   <= '0;
    end else begin
      if (state != GAP && state_d == GAP) begin
        gap_cnt <= CNT_W'(GAP_TICKS - 1);
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - CNT_W'(1);
      end
      if (state == SPAWN && enable) begin
        idx_q <= spawn_idx;
      end
    end
  end

  always_comb begin
    start_d  = 1'b0;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    led_d    = mole_led;
    score_d  = score;
    misses_d = misses;
    if (!enable) begin
      led_d = '0;
    end else begin
      case (state)
        IDLE: led_d = '0;
        SPAWN: begin
          start_d = 1'b1;
          led_d   = N_LEDS'(1) << spawn_idx;
        end
        WAIT: begin
          if (hit) begin
            hit_d   = 1'b1;
            led_d   = '0;
            score_d = (score == 8'hFF) ? score : score + 8'd1;
          end else if (tmo) begin
            miss_d   = 1'b1;
            led_d    = '0;
            misses_d = (misses == 4'hF) ? misses : misses + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      start      <= 1'b0;
      mole_led   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= '0;
      misses     <= '0;
    end else begin
      start      <= start_d;
      mole_led   <= led_d;
      hit_pulse  <= hit_d;
      miss_pulse <= miss_d;
      score      <= score_d;
      misses     <= misses_d;
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Scoreboard bench for mole_spawner: event-timed reference model, queue-based monitor.
module tb_mole_spawner;

  localparam int          N    = 8;
  localparam int          GAP  = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          TAB  = 16384;

  logic         clk_game = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] btn_pulse = '0;
  logic         timeout_pulse = 1'b0;
  logic         start, hit_pulse, miss_pulse;
  logic [N-1:0] mole_led;
  logic [7:0]   score;
  logic [3:0]   misses;

  mole_spawner #(.N_LEDS(N), .GAP_TICKS(GAP), .LFSR_SEED(SEED)) dut (
    .clk_game(clk_game), .rst_n(rst_n), .enable(enable), .btn_pulse(btn_pulse),
    .timeout_pulse(timeout_pulse), .start(start), .mole_led(mole_led),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score), .misses(misses)
  );

  always #5 clk_game = ~clk_game;

  typedef struct {
    int          kind;   // 0 start, 1 hit, 2 miss
    int unsigned cyc;
    logic [N-1:0] led;
    int          score;
    int          misses;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  logic [15:0] lfsr_tab [0:TAB-1];
  int          score_m = 0, miss_m = 0, prev_m = 0, cur_idx = 0;
  int unsigned cur_start = 0;
  int          hits_raw = 0, miss_raw = 0;

  always @(posedge clk_game or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp_v);
    vectors++;
    if (got != exp_v) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp_v);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits start/hit/miss
  always @(negedge clk_game) begin
    if (rst_n) begin
      if (start || hit_pulse || miss_pulse) begin
        int k;
        k = start ? 0 : (hit_pulse ? 1 : 2);
        if (q.size() == 0) begin
          check("unexpected_event", k, -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("event_kind", k, e.kind);
          check("event_cycle", int'(cyc), int'(e.cyc));
          check("mole_led", int'(mole_led), int'(e.led));
          check("score", int'(score), e.score);
          check("misses", int'(misses), e.misses);
          check("pulse_exclusive", int'(start) + int'(hit_pulse) + int'(miss_pulse), 1);
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        exp_t e;
        e = q.pop_front();
        check("missing_event_kind", -1, e.kind);
      end
    end
  end

  task automatic wait_cycle(input int unsigned target);
    while (cyc < target) @(negedge clk_game);
  endtask

  task automatic expect_start(input int unsigned s);
    int raw;
    raw = int'(lfsr_tab[s-1]) % N;
`ifdef MOLE_NO_REPEAT_EN
    if (raw == prev_m) raw = (raw + 1) % N;
`endif
    prev_m    = raw;
    cur_idx   = raw;
    cur_start = s;
    q.push_back('{0, s, N'(1) << raw, score_m, miss_m});
  endtask

  task automatic enable_on();
    enable = 1'b1;
    expect_start(cyc + GAP + 2);
  endtask

  // kind: 0 hit, 1 miss, 2 hit+timeout same cycle, 3 wrong button then timeout
  task automatic run_mole(input int kind, input int d, input bit stale);
    int unsigned w;
    int wrong;
    bit is_hit;
    w = cur_start + d;
    wait_cycle(w);
    is_hit = (kind == 0 || kind == 2);
    if (kind == 3) begin
      wrong = (cur_idx + 1 + $urandom_range(0, N-2)) % N;
      btn_pulse[wrong] = 1'b1;
      @(negedge clk_game);
      btn_pulse = '0;
      w = w + 1;
    end
    if (is_hit) btn_pulse[cur_idx] = 1'b1;
    if (kind != 0) timeout_pulse = 1'b1;
    if (is_hit) begin
      hits_raw++;
      if (score_m < 255) score_m++;
      q.push_back('{1, w + 1, '0, score_m, miss_m});
    end else begin
      miss_raw++;
      if (miss_m < 15) miss_m++;
      q.push_back('{2, w + 1, '0, score_m, miss_m});
    end
    expect_start(w + GAP + 2);
    @(negedge clk_game);
    btn_pulse = '0;
    timeout_pulse = 1'b0;
    if (stale) begin
      // inputs during GAP must be ignored
      timeout_pulse = 1'b1;
      btn_pulse = N'($urandom_range(1, (1 << N) - 1));
      @(negedge clk_game);
      btn_pulse = '0;
      timeout_pulse = 1'b0;
    end
  endtask

  initial begin
    lfsr_tab[0] = SEED;
    for (int i = 1; i < TAB; i++)
      lfsr_tab[i] = (lfsr_tab[i-1] >> 1) ^ (lfsr_tab[i-1][0] ? 16'hB400 : 16'h0000);

    repeat (2) @(posedge clk_game);
    #1;
    check("rst_start", int'(start), 0);
    check("rst_led", int'(mole_led), 0);
    check("rst_hit", int'(hit_pulse), 0);
    check("rst_miss", int'(miss_pulse), 0);
    check("rst_score", int'(score), 0);
    check("rst_misses", int'(misses), 0);
    @(negedge clk_game);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_game);

    enable_on();
    run_mole(0, 0, 1'b1);   // press in the start cycle, stale timeout in GAP
    run_mole(3, 1, 1'b0);   // wrong button, then timeout
    run_mole(2, 2, 1'b0);   // hit and timeout together

    for (int m = 0; m < 1000 && (hits_raw < 260 || miss_raw < 20); m++) begin
      int r, k;
      r = $urandom_range(0, 9);
      k = (r < 7) ? 0 : r - 6;
      run_mole(k, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    wait_cycle(cur_start);
    check("score_saturated", int'(score), 255);
    check("misses_saturated", int'(misses), 15);

    // Drop enable mid-WAIT together with a matching press
    wait_cycle(cur_start + 1);
    enable = 1'b0;
    btn_pulse[cur_idx] = 1'b1;
    @(negedge clk_game);
    btn_pulse = '0;
    check("disable_led_clear", int'(mole_led), 0);
    repeat (3) @(negedge clk_game);
    check("disable_score_held", int'(score), score_m);
    check("disable_misses_held", int'(misses), miss_m);
    enable_on();
    run_mole(0, 1, 1'b0);
    run_mole(1, 0, 1'b0);

    // Asynchronous reset in the middle of WAIT
    wait_cycle(cur_start + 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", int'(mole_led), 0);
    check("async_rst_score", int'(score), 0);
    check("async_rst_misses", int'(misses), 0);
    check("async_rst_queue", q.size(), 0);
    q.delete();
    enable = 1'b0;
    score_m = 0; miss_m = 0; prev_m = 0;
    @(negedge clk_game);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_game);
    enable_on();
    run_mole(0, 0, 1'b0);
    run_mole(1, 2, 1'b0);
    run_mole(3, 0, 1'b0);
    run_mole(0, 3, 1'b0);

    wait_cycle(cur_start + 2);
    check("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
